uart_tx_scheduler: RTL and testbench

//  Reference-clock-domain scheduler that queues response bytes for the UART transmitter.
//  - Accepts 16-bit ALU results (sent as two bytes, low byte first) and 8-bit register-file read data into a byte FIFO.
//  - Presents one byte at a time to the transmitter data synchronizer.
//  - Holds valid until the synchronizer acknowledges capture, then waits for the transmitter busy/idle cycle before sending the next byte.

---
 rtl/uart_tx_scheduler.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Queues response bytes for the UART transmitter in the reference clock domain.
// ALU results are split into two bytes (low byte first) and register-file read
// data is queued as a single byte. Bytes leave the FIFO one at a time. Each byte
// is offered until the TX data synchronizer acknowledges it. The scheduler then
// waits for the transmitter to go busy and return to idle before it offers the
// next byte.
//
// Ports
//   clk, reset                         reference clock, synchronous active-high reset
//   ALU_result_valid / ALU_result      1-cycle request carrying a 2*DATA_WIDTH result
//   register_file_read_data_valid /
//   register_file_read_data            1-cycle request carrying one byte
//   transmitter_Q_pulse_generator      capture-ack pulse from the TX data synchronizer
//   transmitter_busy_synchronized      UART TX busy flag, already in the clk domain
//   transmitter_parallel_data_valid    byte currently offered to the synchronizer
//   transmitter_parallel_data          offered byte, held from one launch to the next
//   fifo_count                         number of queued bytes
//   overflow                           1-cycle pulse when a request is dropped
//   busy_timeout                       1-cycle pulse when the TX never reported busy
//   scheduler_idle                     FIFO empty and nothing in flight
module uart_tx_scheduler #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ALU_result_valid,
    input  logic [2*DATA_WIDTH-1:0]         ALU_result,
    input  logic                            register_file_read_data_valid,
    input  logic [DATA_WIDTH-1:0]           register_file_read_data,
    input  logic                            transmitter_Q_pulse_generator,
    input  logic                            transmitter_busy_synchronized,
    output logic                            transmitter_parallel_data_valid,
    output logic [DATA_WIDTH-1:0]           transmitter_parallel_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    output logic                            busy_timeout,
    output logic                            scheduler_idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_IDLE = 2'd3;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [1:0]            state;
    logic [TMR_W-1:0]      timer;
    logic [TMR_W-1:0]      timer_inc;

    logic [CNT_W-1:0]      free;
    logic [CNT_W-1:0]      free_after_alu;
    logic [CNT_W-1:0]      alu_bytes;
    logic [CNT_W-1:0]      rd_bytes;
    logic [CNT_W-1:0]      pop_bytes;
    logic                  alu_push;
    logic                  rd_push;
    logic                  pop;

    // Space is judged on the registered count only; a pop in the same cycle
    // does not make room for this cycle's pushes.
    always_comb begin
        free           = CNT_W'(FIFO_DEPTH) - fifo_count;
        alu_push       = ALU_result_valid && (free >= CNT_W'(2));
        alu_bytes      = alu_push ? CNT_W'(2) : '0;
        free_after_alu = free - alu_bytes;
        rd_push        = register_file_read_data_valid && (free_after_alu != '0);
        rd_bytes       = CNT_W'(rd_push);
        pop            = (state == ST_IDLE) && (fifo_count != '0);
        pop_bytes      = CNT_W'(pop);
        timer_inc      = timer + TMR_W'(1);
    end

    assign scheduler_idle = (fifo_count == '0) && (state == ST_IDLE);

    // Storage is not reset; the pointers and count define what is valid.
    // The register byte always lands after both ALU bytes of the same cycle.
    always_ff @(posedge clk) begin
        if (alu_push) begin
            mem[wr_ptr]              <= ALU_result[DATA_WIDTH-1:0];
            mem[wr_ptr + PTR_W'(1)]  <= ALU_result[2*DATA_WIDTH-1:DATA_WIDTH];
        end
        if (rd_push) begin
            mem[wr_ptr + PTR_W'(alu_bytes)] <= register_file_read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + PTR_W'(alu_bytes + rd_bytes);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count + alu_bytes + rd_bytes - pop_bytes;
            overflow   <= (ALU_result_valid && !alu_push) ||
                          (register_file_read_data_valid && !rd_push);
        end
    end

    // The data register is loaded only on the IDLE->LAUNCH pop, so it cannot
    // change while valid is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                           <= ST_IDLE;
            transmitter_parallel_data_valid <= 1'b0;
            transmitter_parallel_data       <= '0;
            timer                           <= '0;
            busy_timeout                    <= 1'b0;
        end else begin
            busy_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        transmitter_parallel_data       <= mem[rd_ptr];
                        transmitter_parallel_data_valid <= 1'b1;
                        state                           <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (transmitter_Q_pulse_generator) begin
                        transmitter_parallel_data_valid <= 1'b0;
                        timer                           <= '0;
                        state                           <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    // A byte that never makes the transmitter go busy is
                    // abandoned so the queue cannot stall forever.
                    if (transmitter_busy_synchronized) begin
                        state <= ST_WAIT_IDLE;
                    end else if (timer_inc == TMR_W'(BUSY_TIMEOUT)) begin
                        busy_timeout <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!transmitter_busy_synchronized) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
// Directed bench for uart_tx_scheduler. A transaction-level model (byte queue
// plus handshake phase) predicts every output and is compared on each falling
// edge. Directed sequences add hand-computed literal expectations.
module tb_uart_tx_scheduler;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 255;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          alu_v = 1'b0;
    logic [15:0]   alu = '0;
    logic          rd_v = 1'b0;
    logic [7:0]    rd = '0;
    logic          ack = 1'b0;
    logic          busy = 1'b0;

    logic          txv;
    logic [7:0]    txd;
    logic [2:0]    cnt;
    logic          ovf;
    logic          tmo;
    logic          idle;

    uart_tx_scheduler #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .BUSY_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ALU_result_valid(alu_v),
        .ALU_result(alu),
        .register_file_read_data_valid(rd_v),
        .register_file_read_data(rd),
        .transmitter_Q_pulse_generator(ack),
        .transmitter_busy_synchronized(busy),
        .transmitter_parallel_data_valid(txv),
        .transmitter_parallel_data(txd),
        .fifo_count(cnt),
        .overflow(ovf),
        .busy_timeout(tmo),
        .scheduler_idle(idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];
    logic [7:0] m_new[$];
    int         m_phase = 0;   // 0 idle, 1 offering, 2 waiting for busy, 3 waiting for idle
    int         m_wait = 0;
    int         m_free;
    int         m_added;
    logic       m_pop;
    logic [7:0] m_head;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = '0;
    logic       m_ovf = 1'b0;
    logic       m_tmo = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_phase = 0;
            m_wait  = 0;
            m_valid = 1'b0;
            m_data  = '0;
            m_ovf   = 1'b0;
            m_tmo   = 1'b0;
        end else begin
            m_tmo   = 1'b0;
            m_ovf   = 1'b0;
            m_pop   = (m_phase == 0) && (mq.size() != 0);
            m_free  = DEPTH - mq.size();
            m_added = 0;
            m_new.delete();
            if (alu_v) begin
                if (m_free >= 2) begin
                    m_new.push_back(alu[7:0]);
                    m_new.push_back(alu[15:8]);
                    m_added = 2;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (rd_v) begin
                if (m_free - m_added >= 1) m_new.push_back(rd);
                else m_ovf = 1'b1;
            end
            if (m_pop) m_head = mq.pop_front();
            foreach (m_new[i]) mq.push_back(m_new[i]);
            case (m_phase)
                0: if (m_pop) begin m_data = m_head; m_valid = 1'b1; m_phase = 1; end
                1: if (ack) begin m_valid = 1'b0; m_phase = 2; m_wait = 0; end
                2: begin
                    if (busy) m_phase = 3;
                    else begin
                        m_wait++;
                        if (m_wait == TMO) begin m_tmo = 1'b1; m_phase = 0; end
                    end
                end
                3: if (!busy) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- compare + launch log ----------------
    logic [7:0] log_q[$];
    logic       prev_v = 1'b0;
    logic       ovf_seen = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            chk("valid", txv, m_valid);
            chk("data", txd, m_data);
            chk("count", cnt, mq.size());
            chk("overflow", ovf, m_ovf);
            chk("busy_timeout", tmo, m_tmo);
            chk("idle", idle, (mq.size() == 0) && (m_phase == 0));
            if (txv && !prev_v) log_q.push_back(txd);
            if (ovf) ovf_seen = 1'b1;
            prev_v = txv;
        end else begin
            prev_v = 1'b0;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_rd(input logic [7:0] b);
        rd = b; rd_v = 1'b1;
        step(1);
        rd_v = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!txv && n < 60) begin
            step(1);
            n++;
        end
        chk("launch_seen", txv, 1);
    endtask

    // Accept the offered byte and play one busy 1->0 cycle; a stray ack while
    // the transmitter is busy must be ignored.
    task automatic serve(input logic [7:0] exp);
        wait_valid();
        chk("served_byte", txd, exp);
        step(2);
        ack = 1'b1; step(1); ack = 1'b0;
        step(2);
        busy = 1'b1; step(1);
        ack = 1'b1; step(1); ack = 1'b0;
        step(2);
        busy = 1'b0;
        step(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        chk("rst_valid", txv, 0);
        chk("rst_data", txd, 0);
        chk("rst_count", cnt, 0);
        chk("rst_overflow", ovf, 0);
        chk("rst_timeout", tmo, 0);
        chk("rst_idle", idle, 1);
        step(2);

        // One ALU result: low byte then high byte, latency N+1 / N+2
        log_q.delete();
        alu = 16'hA55A; alu_v = 1'b1;
        step(1);
        alu_v = 1'b0;
        chk("alu_count", cnt, 2);
        chk("latency_n1", txv, 0);
        step(1);
        chk("latency_n2", txv, 1);
        serve(8'h5A);
        serve(8'hA5);
        chk("a55a_len", log_q.size(), 2);
        chk("a55a_0", log_q[0], 8'h5A);
        chk("a55a_1", log_q[1], 8'hA5);

        // Simultaneous ALU + register byte
        log_q.delete();
        ovf_seen = 1'b0;
        alu = 16'h1234; rd = 8'h77; alu_v = 1'b1; rd_v = 1'b1;
        step(1);
        alu_v = 1'b0; rd_v = 1'b0;
        chk("both_count", cnt, 3);
        serve(8'h34);
        serve(8'h12);
        serve(8'h77);
        chk("both_len", log_q.size(), 3);
        chk("both_0", log_q[0], 8'h34);
        chk("both_1", log_q[1], 8'h12);
        chk("both_2", log_q[2], 8'h77);
        chk("both_no_ovf", ovf_seen, 0);

        // Overflow with 3 bytes queued: whole ALU result dropped
        log_q.delete();
        push_rd(8'h01);
        wait_valid();
        push_rd(8'h02);
        push_rd(8'h03);
        push_rd(8'h04);
        chk("fill_count", cnt, 3);
        alu = 16'hBEEF; alu_v = 1'b1;
        step(1);
        alu_v = 1'b0;
        chk("ovf_pulse", ovf, 1);
        chk("ovf_count", cnt, 3);
        step(1);
        chk("ovf_clear", ovf, 0);
        serve(8'h01);
        serve(8'h02);
        serve(8'h03);
        serve(8'h04);
        chk("ovf_len", log_q.size(), 4);
        chk("ovf_last", log_q[3], 8'h04);

        // Busy timeout after 255 cycles, then the next byte launches
        log_q.delete();
        push_rd(8'h55);
        push_rd(8'h66);
        wait_valid();
        chk("tmo_first", txd, 8'h55);
        step(1);
        ack = 1'b1; step(1); ack = 1'b0;
        n = 0;
        while (!tmo && n < 300) begin
            step(1);
            n++;
        end
        chk("tmo_cycles", n, 255);
        chk("tmo_pulse", tmo, 1);
        step(1);
        chk("tmo_once", tmo, 0);
        serve(8'h66);
        chk("tmo_len", log_q.size(), 2);
        chk("tmo_next", log_q[1], 8'h66);

        // Push in the same cycle as the IDLE->LAUNCH pop
        log_q.delete();
        push_rd(8'h90);
        wait_valid();
        step(1);
        ack = 1'b1; step(1); ack = 1'b0;
        busy = 1'b1; step(1);
        push_rd(8'h88);
        chk("pp_count_pre", cnt, 1);
        step(1);
        busy = 1'b0;
        step(1);
        chk("pp_not_idle", idle, 0);
        rd = 8'hC3; rd_v = 1'b1;
        step(1);
        rd_v = 1'b0;
        chk("pp_count_post", cnt, 1);
        chk("pp_valid", txv, 1);
        chk("pp_data", txd, 8'h88);
        serve(8'h88);
        serve(8'hC3);
        chk("pp_len", log_q.size(), 3);
        chk("pp_1", log_q[1], 8'h88);
        chk("pp_2", log_q[2], 8'hC3);

        // Reset while a byte is offered
        push_rd(8'h11);
        push_rd(8'h22);
        wait_valid();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_rst_valid", txv, 0);
        chk("mid_rst_count", cnt, 0);
        chk("mid_rst_idle", idle, 1);
        step(5);
        chk("mid_rst_stay", txv, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
